// File: rtl/pong_game.sv
// -----------------------------------------------------------------------------
// pong_game
//   Game engine and pixel renderer for a 640x480p60 Pong. Sits directly after
//   the display timing generator. All game state (ball, paddles, scores, FSM)
//   changes once per frame on the frame tick (first pixel of the first
//   blanking line). The pixel colour, syncs and DE are registered together,
//   giving one cycle of latency on every vga_* output.
//
// Ports
//   clk_pix, rst_pix       pixel clock; asynchronous active-high reset
//   sx, sy                 current pixel position from the timing generator
//   hsync, vsync, de       timing generator syncs (negative) and data enable
//   btn_up, btn_dn         left player controls, already synchronised
//   vga_hsync/vsync/de     inputs delayed one cycle
//   vga_r, vga_g, vga_b    4-bit pixel colour, aligned with vga_de
//   score_l, score_r       current scores
// -----------------------------------------------------------------------------
module pong_game #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int BALL_SIZE    = 8,
   parameter int BALL_SPD     = 2,
   parameter int PAD_W        = 10,
   parameter int PAD_H        = 48,
   parameter int PAD_OFFS     = 32,
   parameter int PAD_SPD      = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clk_pix,
   input  logic       rst_pix,
   input  logic [9:0] sx,
   input  logic [9:0] sy,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       de,
   input  logic       btn_up,
   input  logic       btn_dn,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic       vga_de,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic [3:0] score_l,
   output logic [3:0] score_r
);

   // All geometry is held in 11 bits so that no sum of a position and a size
   // or speed can wrap.
   localparam logic [10:0] HR     = 11'(H_RES);
   localparam logic [10:0] VR     = 11'(V_RES);
   localparam logic [10:0] BS     = 11'(BALL_SIZE);
   localparam logic [10:0] BSPD   = 11'(BALL_SPD);
   localparam logic [10:0] PH     = 11'(PAD_H);
   localparam logic [10:0] PSPD   = 11'(PAD_SPD);
   localparam logic [10:0] PO     = 11'(PAD_OFFS);
   localparam logic [10:0] EL     = 11'(PAD_OFFS + PAD_W);          // left paddle face
   localparam logic [10:0] ER     = 11'(H_RES - PAD_OFFS - PAD_W);  // right paddle face
   localparam logic [10:0] PR_END = 11'(H_RES - PAD_OFFS);
   localparam logic [10:0] BX0    = 11'((H_RES - BALL_SIZE) / 2);
   localparam logic [10:0] BY0    = 11'((V_RES - BALL_SIZE) / 2);
   localparam logic [10:0] PY0    = 11'((V_RES - PAD_H) / 2);
   localparam logic [10:0] PY_MAX = 11'(V_RES - PAD_H);
   localparam logic [10:0] NET_L  = 11'(H_RES / 2 - 2);
   localparam logic [10:0] NET_R  = 11'(H_RES / 2 + 1);
   localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
   localparam int          CNT_W  = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

   typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

   // Registered game state and its next values
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [10:0]       bx, bx_n, by, by_n;
   logic              dx_r, dx_r_n;      // 1: ball moving right
   logic              dy_d, dy_d_n;      // 1: ball moving down
   logic [10:0]       py_l, py_l_n, py_r, py_r_n;
   logic [3:0]        score_l_n, score_r_n;

   // Per-tick helper terms
   logic        ftick;
   logic        ai_up, ai_dn;
   logic        ovl_l, ovl_r;
   logic        goal_l, goal_r;
   logic [3:0]  new_score;

   assign ftick = (sy == 10'(V_RES)) && (sx == 10'd0);

   // The AI chases the ball using the pre-tick positions.
   assign ai_up = by < py_r;
   assign ai_dn = !ai_up && (by + BS > py_r + PH);

   assign ovl_l = (by + BS > py_l) && (by < py_l + PH);
   assign ovl_r = (by + BS > py_r) && (by < py_r + PH);

   // One paddle step; both or neither direction holds position.
   function automatic logic [10:0] pad_step(input logic [10:0] py,
                                            input logic up, input logic dn);
      logic [10:0] res;
      res = py;
      if (up && !dn)
         res = (py < PSPD) ? 11'd0 : py - PSPD;
      else if (dn && !up)
         res = (py + PSPD > PY_MAX) ? PY_MAX : py + PSPD;
      return res;
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s == 4'hF) ? 4'hF : s + 4'd1;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state   <= SERVE;
         cnt     <= '0;
         bx      <= BX0;
         by      <= BY0;
         dx_r    <= 1'b1;
         dy_d    <= 1'b1;
         py_l    <= PY0;
         py_r    <= PY0;
         score_l <= 4'd0;
         score_r <= 4'd0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bx      <= bx_n;
         by      <= by_n;
         dx_r    <= dx_r_n;
         dy_d    <= dy_d_n;
         py_l    <= py_l_n;
         py_r    <= py_r_n;
         score_l <= score_l_n;
         score_r <= score_r_n;
      end
   end

   // NOTE: every variable written here gets a default first, so no path
   // through the block can leave one unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bx_n      = bx;
      by_n      = by;
      dx_r_n    = dx_r;
      dy_d_n    = dy_d;
      py_l_n    = py_l;
      py_r_n    = py_r;
      score_l_n = score_l;
      score_r_n = score_r;
      goal_l    = 1'b0;
      goal_r    = 1'b0;
      new_score = 4'd0;

      if (ftick) begin
         case (state)
            SERVE: begin
               py_l_n = pad_step(py_l, btn_up, btn_dn);
               py_r_n = pad_step(py_r, ai_up, ai_dn);
               if (cnt == SERVE_LAST) begin
                  state_n = PLAY;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end

            PLAY: begin
               py_l_n = pad_step(py_l, btn_up, btn_dn);
               py_r_n = pad_step(py_r, ai_up, ai_dn);

               // Vertical: bounce off top and bottom walls.
               if (!dy_d) begin
                  if (by < BSPD) begin
                     by_n   = 11'd0;
                     dy_d_n = 1'b1;
                  end else begin
                     by_n = by - BSPD;
                  end
               end else if (by + BS + BSPD > VR) begin
                  by_n   = VR - BS;
                  dy_d_n = 1'b0;
               end else begin
                  by_n = by + BSPD;
               end

               // Horizontal: a paddle hit only counts when the ball is about to
               // cross the face this tick, so a ball already past it is lost.
               if (!dx_r) begin
                  if (bx >= EL && bx - BSPD < EL && ovl_l) begin
                     bx_n   = EL;
                     dx_r_n = 1'b1;
                  end else if (bx < BSPD) begin
                     goal_r = 1'b1;
                  end else begin
                     bx_n = bx - BSPD;
                  end
               end else begin
                  if (bx + BS <= ER && bx + BS + BSPD > ER && ovl_r) begin
                     bx_n   = ER - BS;
                     dx_r_n = 1'b0;
                  end else if (bx + BS + BSPD > HR) begin
                     goal_l = 1'b1;
                  end else begin
                     bx_n = bx + BSPD;
                  end
               end

               // A goal overrides the ball update: re-centre, serve toward the
               // player who conceded, keep the vertical direction held before
               // this tick.
               if (goal_l || goal_r) begin
                  bx_n   = BX0;
                  by_n   = BY0;
                  dy_d_n = dy_d;
                  dx_r_n = goal_l;
                  cnt_n  = '0;
                  if (goal_l) begin
                     new_score = sat_inc(score_l);
                     score_l_n = new_score;
                  end else begin
                     new_score = sat_inc(score_r);
                     score_r_n = new_score;
                  end
                  state_n = (new_score == WIN) ? OVER : SERVE;
               end
            end

            OVER: begin
               if (btn_up && btn_dn) begin
                  score_l_n = 4'd0;
                  score_r_n = 4'd0;
                  bx_n      = BX0;
                  by_n      = BY0;
                  py_l_n    = PY0;
                  py_r_n    = PY0;
                  cnt_n     = '0;
                  state_n   = SERVE;
               end
            end

            default: state_n = SERVE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Renderer: draws from the registered state only, so a tick on this edge
   // does not affect the pixel emitted for it.
   // ---------------------------------------------------------------------------
   logic [10:0] sx_e, sy_e;
   logic        in_ball, in_pad_l, in_pad_r, on_net;
   logic [11:0] colour;

   assign sx_e = {1'b0, sx};
   assign sy_e = {1'b0, sy};

   assign in_ball  = (sx_e >= bx) && (sx_e < bx + BS) &&
                     (sy_e >= by) && (sy_e < by + BS) && (state != OVER);
   assign in_pad_l = (sx_e >= PO) && (sx_e < EL) &&
                     (sy_e >= py_l) && (sy_e < py_l + PH);
   assign in_pad_r = (sx_e >= ER) && (sx_e < PR_END) &&
                     (sy_e >= py_r) && (sy_e < py_r + PH);
   assign on_net   = (sx_e >= NET_L) && (sx_e <= NET_R) && !sy[3];

   always_comb begin
      colour = 12'h000;
      if (!de)
         colour = 12'h000;
      else if (in_ball || in_pad_l || in_pad_r)
         colour = 12'hFFF;
      else if (on_net)
         colour = 12'h888;
      else if (state == OVER)
         colour = 12'h400;
      else
         colour = 12'h113;
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
         vga_de    <= 1'b0;
         vga_r     <= 4'h0;
         vga_g     <= 4'h0;
         vga_b     <= 4'h0;
      end else begin
         vga_hsync <= hsync;
         vga_vsync <= vsync;
         vga_de    <= de;
         {vga_r, vga_g, vga_b} <= colour;
      end
   end

endmodule

// File: tb/tb_pong_game.sv
// -----------------------------------------------------------------------------
// tb_pong_game
//   Self-checking bench for pong_game. Frames are compressed: each "frame" is a
//   single tick pixel (sx=0, sy=480) followed by a handful of probe pixels
//   around the ball and paddles plus one random pixel. A reference model of the
//   game rules (plain integer arithmetic) predicts scores and every probed
//   colour; syncs and DE are checked against the inputs of the previous cycle.
// -----------------------------------------------------------------------------
module tb_pong_game;

   localparam int NTICKS = 4500;

   logic       clk_pix = 1'b0;
   logic       rst_pix = 1'b1;
   logic [9:0] sx = '0, sy = '0;
   logic       hsync = 1'b1, vsync = 1'b1, de = 1'b0;
   logic       btn_up = 1'b0, btn_dn = 1'b0;
   logic       vga_hsync, vga_vsync, vga_de;
   logic [3:0] vga_r, vga_g, vga_b, score_l, score_r;

   int n_checks = 0;
   int n_errors = 0;

   pong_game dut (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .sx        (sx),
      .sy        (sy),
      .hsync     (hsync),
      .vsync     (vsync),
      .de        (de),
      .btn_up    (btn_up),
      .btn_dn    (btn_dn),
      .vga_hsync (vga_hsync),
      .vga_vsync (vga_vsync),
      .vga_de    (vga_de),
      .vga_r     (vga_r),
      .vga_g     (vga_g),
      .vga_b     (vga_b),
      .score_l   (score_l),
      .score_r   (score_r)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // st: 0 serve, 1 play, 2 over
   int m_bx, m_by, m_pyl, m_pyr, m_sl, m_sr, m_st, m_cnt;
   bit m_dxr, m_dyd;

   task automatic model_reset();
      m_bx = 316; m_by = 236; m_dxr = 1; m_dyd = 1;
      m_pyl = 216; m_pyr = 216; m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0;
   endtask

   function automatic int pad_move(int py, int dir);
      if (dir < 0) return (py < 4) ? 0 : py - 4;
      if (dir > 0) return (py + 4 > 432) ? 432 : py + 4;
      return py;
   endfunction

   task automatic model_tick(input bit up, input bit dn);
      int opl, opr, nbx, nby, sc;
      bit ndx, ndy, gl, gr, ovl, ovr;
      opl = m_pyl; opr = m_pyr;
      nbx = m_bx; nby = m_by; ndx = m_dxr; ndy = m_dyd; gl = 0; gr = 0;
      if (m_st == 2) begin
         if (up && dn) begin
            m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236;
            m_pyl = 216; m_pyr = 216; m_st = 0; m_cnt = 0;
         end
         return;
      end
      m_pyl = pad_move(opl, (up && !dn) ? -1 : ((dn && !up) ? 1 : 0));
      m_pyr = pad_move(opr, (m_by < opr) ? -1 : ((m_by + 8 > opr + 48) ? 1 : 0));
      if (m_st == 0) begin
         if (m_cnt == 59) begin m_st = 1; m_cnt = 0; end
         else m_cnt++;
         return;
      end
      if (m_dyd) begin
         if (m_by + 10 > 480) begin nby = 472; ndy = 0; end else nby = m_by + 2;
      end else begin
         if (m_by < 2) begin nby = 0; ndy = 1; end else nby = m_by - 2;
      end
      ovl = (m_by + 8 > opl) && (m_by < opl + 48);
      ovr = (m_by + 8 > opr) && (m_by < opr + 48);
      if (!m_dxr) begin
         if (m_bx >= 42 && m_bx - 2 < 42 && ovl) begin nbx = 42; ndx = 1; end
         else if (m_bx < 2) gr = 1;
         else nbx = m_bx - 2;
      end else begin
         if (m_bx + 8 <= 598 && m_bx + 10 > 598 && ovr) begin nbx = 590; ndx = 0; end
         else if (m_bx + 10 > 640) gl = 1;
         else nbx = m_bx + 2;
      end
      if (gl || gr) begin
         nbx = 316; nby = 236; ndy = m_dyd; ndx = gl; m_cnt = 0;
         if (gl) begin m_sl = (m_sl == 15) ? 15 : m_sl + 1; sc = m_sl; end
         else begin m_sr = (m_sr == 15) ? 15 : m_sr + 1; sc = m_sr; end
         m_st = (sc == 9) ? 2 : 0;
      end
      m_bx = nbx; m_by = nby; m_dxr = ndx; m_dyd = ndy;
   endtask

   function automatic logic [11:0] exp_rgb(int x, int y, bit d);
      if (!d) return 12'h000;
      if (m_st != 2 && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 12'hFFF;
      if (x >= 32 && x < 42 && y >= m_pyl && y < m_pyl + 48) return 12'hFFF;
      if (x >= 598 && x < 608 && y >= m_pyr && y < m_pyr + 48) return 12'hFFF;
      if (x >= 318 && x <= 321 && ((y / 8) % 2) == 0) return 12'h888;
      return (m_st == 2) ? 12'h400 : 12'h113;
   endfunction

   // ---------------- stimulus helpers ----------------
   // Drive one pixel, then check the registered colour and delayed syncs.
   task automatic px(input int x, input int y, input bit d);
      logic hs, vs;
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      @(negedge clk_pix);
      sx = 10'(x); sy = 10'(y); de = d; hsync = hs; vsync = vs;
      @(posedge clk_pix);
      #1;
      check("pixel_rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb(x, y, d)));
      check("sync_de", 32'({vga_hsync, vga_vsync, vga_de}), 32'({hs, vs, d}));
   endtask

   // Frame tick with the given buttons, then the model advances.
   task automatic tick(input bit up, input bit dn);
      @(negedge clk_pix);
      sx = 10'd0; sy = 10'd480; de = 1'b0; hsync = 1'b1; vsync = 1'b0;
      btn_up = up; btn_dn = dn;
      @(posedge clk_pix);
      #1;
      check("tick_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
      model_tick(up, dn);
      check("score_l", 32'(score_l), 32'(m_sl));
      check("score_r", 32'(score_r), 32'(m_sr));
   endtask

   function automatic int edge_off(int base);
      case ($urandom_range(0, 3))
         0: return base - 1;
         1: return base;
         2: return base + 47;
         default: return base + 48;
      endcase
   endfunction

   task automatic probes();
      px(m_bx, m_by, 1'b1);
      px(m_bx + 7, m_by + 7, 1'b1);
      px(($urandom_range(0, 1) != 0) ? m_bx + 8 : m_bx - 1, m_by + int'($urandom_range(0, 7)), 1'b1);
      px(int'($urandom_range(31, 42)), edge_off(m_pyl), 1'b1);
      px(int'($urandom_range(597, 608)), edge_off(m_pyr), 1'b1);
      px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), ($urandom_range(0, 9) != 0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int r;
      bit up, dn;
      model_reset();

      // Reset held over clock edges
      repeat (2) @(posedge clk_pix);
      #1;
      check("reset_out", 32'({vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b}), 32'({3'b110, 12'h000}));
      check("reset_score", 32'({score_l, score_r}), 32'h0);
      @(negedge clk_pix);
      rst_pix = 1'b0;

      // Ball at the centre is drawn white; DE low blanks it.
      px(320, 240, 1'b1);
      px(320, 240, 1'b0);
      px(320, 240, 1'b1);

      // Asynchronous reset between clock edges clears outputs immediately.
      #1 rst_pix = 1'b1;
      #1;
      check("async_reset", 32'({vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b}), 32'({3'b110, 12'h000}));
      @(posedge clk_pix);
      @(negedge clk_pix);
      rst_pix = 1'b0;
      model_reset();

      // Serve with btn_up held: paddle climbs to the top and saturates,
      // ball stays put until the first play tick.
      for (int i = 0; i < 62; i++) begin
         tick(1'b1, 1'b0);
         probes();
         px(35, 0, 1'b1);
      end

      // Randomised play, including simultaneous presses (hold / restart).
      for (int i = 0; i < NTICKS; i++) begin
         r  = int'($urandom_range(0, 9));
         up = (r <= 2) || (r == 6) || (m_st == 2 && r >= 7);
         dn = (r >= 3 && r <= 6) || (m_st == 2 && r >= 7);
         tick(up, dn);
         probes();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
